waveform_buffer: RTL and testbench
==================================

// Module: waveform_buffer
//
// PURPOSE
// Circular sample store that sits directly upstream of the waveform trace renderer. Captures
// decimated 8-bit heart-signal samples into a DEPTH-entry ring and replays them per screen column,
// so signal_out is the sample for the column hcount is drawing (oldest at left, newest at right).
// Read-side base pointer is latched once per frame (tear-free); freeze holds the trace for inspection.
//
// PARAMETERS
// DEPTH     1024  ring entries = trace width in pixels; power of two
// AW        10    address width, log2(DEPTH)
// X_BEGIN   296   hcount of trace column 0; must match the renderer's x origin
// DECIMATE  4     store 1 of every DECIMATE accepted samples (1 = store every sample)
//
// PORTS
// clock         in   1   pixel clock; all logic on rising edge
// reset_n       in   1   asynchronous, active-low reset
// sample_valid  in   1   one-cycle strobe: sample_in is a new sample
// sample_in     in   8   unsigned sample from the signal-conditioning stage
// freeze        in   1   level: 1 = suppress writes, hold displayed trace
// hcount        in   11  current horizontal pixel count from the XVGA timing generator
// vcount        in   10  current vertical line count from the XVGA timing generator
// signal_out    out  8   sample for column (hcount - X_BEGIN); drives the renderer's signal_in
// wr_ptr        out  AW  next ring address to be written
// buffer_full   out  1   1 once DEPTH samples have been stored since reset
//
// BEHAVIOUR
// Reset (reset_n=0, async): wr_ptr=0, decim_cnt=0, fill_cnt=0, buffer_full=0, frame_base=0,
//   frame_fill=0, signal_out=0, state=FILL. Ring RAM is not cleared; fill_cnt masks stale data.
// Write side:
//  - Sample accepted when sample_valid=1 and state != HOLD.
//  - decim_cnt counts accepted samples 0..DECIMATE-1; on the accept where decim_cnt==DECIMATE-1:
//    ram[wr_ptr]<=sample_in, wr_ptr<=wr_ptr+1 (mod DEPTH, natural AW-bit wrap), decim_cnt<=0.
//  - fill_cnt (AW+1 bits) increments per stored sample, saturates at DEPTH.
//  - In HOLD, decim_cnt also holds; no partial decimation progress is lost or gained.
// State machine (registered):
//  - FILL: fill_cnt<DEPTH. -> RUN when the store making fill_cnt==DEPTH occurs; -> HOLD if freeze=1.
//  - RUN:  ring full, oldest sample = ram[wr_ptr]. -> HOLD if freeze=1.
//  - HOLD: no writes. freeze=0 -> RUN if fill_cnt==DEPTH, else FILL.
//  - buffer_full = (fill_cnt==DEPTH), registered; stays 1 through HOLD.
// Frame latch:
//  - On hcount==0 && vcount==0: frame_base <= (fill_cnt==DEPTH) ? wr_ptr : 0; frame_fill <= fill_cnt.
//  - Simultaneous store in that cycle: latch takes pre-store wr_ptr/fill_cnt; the new sample shows next frame.
//  - Base/fill constant for the rest of the frame regardless of writes or freeze.
// Read side (1-cycle latency, hidden by lookahead):
//  - col = (hcount + 1) - X_BEGIN, computed 12-bit signed; rd_addr = frame_base + col[AW-1:0] (mod DEPTH).
//  - Synchronous RAM read; signal_out registered. Result: signal_out valid in the cycle hcount==X_BEGIN+c
//    carries column c.
//  - signal_out <= 0 when col<0, col>=DEPTH, or col>=frame_fill (unwritten columns).
//  - Write and read of same address same cycle: read returns old data (read-first); no hazard required.
//  - Reset mid-frame: signal_out=0 immediately, trace blank until next frame latch after stores resume.
//
// TESTING
// 1 Reset, DECIMATE=1, store 5 samples 10,20,30,40,50, frame start -> hcount=296..300 gives 10..50,
//   hcount=301 gives 0, buffer_full=0.
// 2 DECIMATE=4, 8 valid strobes of value k=1..8 -> only 4 and 8 stored, wr_ptr=2.
// 3 Store 1030 samples (value=index mod 256), frame start -> wr_ptr=6, buffer_full=1,
//   hcount=296 gives 6, hcount=1319 gives 1029 mod 256=5 (newest at right).
// 4 Full ring, freeze=1 for 3 frames with sample_valid toggling -> wr_ptr unchanged, identical
//   signal_out sequence each frame; freeze=0 -> writes resume, state=RUN.
// 5 sample_valid coincident with hcount=0,vcount=0 -> sample absent this frame, present next frame.
// 6 Assert reset_n=0 mid-line at hcount=500 -> signal_out=0 that cycle (async), wr_ptr=0, buffer_full=0.

Source files
------------

// File: rtl/waveform_buffer_if.sv
// Sample-capture and per-column replay signals between the conditioning stage,
// the XVGA timing generator and the waveform renderer.
interface waveform_buffer_if #(
  parameter int unsigned AW = 10
);
  logic          sample_valid;
  logic [7:0]    sample_in;
  logic          freeze;
  logic [10:0]   hcount;
  logic [9:0]    vcount;
  logic [7:0]    signal_out;
  logic [AW-1:0] wr_ptr;
  logic          buffer_full;

  modport master (
    output sample_valid, sample_in, freeze, hcount, vcount,
    input  signal_out, wr_ptr, buffer_full
  );

  modport slave (
    input  sample_valid, sample_in, freeze, hcount, vcount,
    output signal_out, wr_ptr, buffer_full
  );
endinterface

// File: rtl/waveform_buffer.sv
// Decimating circular sample store replayed one sample per screen column,
// with a per-frame latched read base so the trace never tears mid-frame.
module waveform_buffer #(
  parameter int unsigned DEPTH    = 1024,
  parameter int unsigned AW       = 10,
  parameter int unsigned X_BEGIN  = 296,
  parameter int unsigned DECIMATE = 4
) (
  input logic         clock,
  input logic         reset_n,
  waveform_buffer_if.slave bus
);
  localparam int unsigned DW  = 8;
  localparam int unsigned FW  = AW + 1;
  localparam int unsigned CW  = 12;
  localparam int unsigned DCW = (DECIMATE > 1) ? $clog2(DECIMATE) : 1;

  typedef enum logic [1:0] {FILL, RUN, HOLD} state_t;

  state_t          state, state_nxt;
  logic [DW-1:0]   ram [DEPTH];
  logic [DCW-1:0]  decim_cnt;
  logic [FW-1:0]   fill_cnt, frame_fill;
  logic [AW-1:0]   wr_ptr, frame_base;
  logic [DW-1:0]   signal_out;
  logic            buffer_full;

  logic            accept_c, store_c, ring_full_c, frame_start_c, col_ok_c;
  logic [FW-1:0]   fill_nxt_c;
  logic [CW-1:0]   col_c;
  logic [AW-1:0]   rd_addr_c;

  assign ring_full_c   = (fill_cnt == FW'(DEPTH));
  assign frame_start_c = (bus.hcount == '0) && (bus.vcount == '0);

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= FILL;
    else          state <= state_nxt;
  end

  // Accept/store qualification and next-state logic
  always_comb begin
    state_nxt  = state;
    accept_c   = bus.sample_valid && (state != HOLD);
    store_c    = accept_c && (decim_cnt == DCW'(DECIMATE - 1));
    fill_nxt_c = fill_cnt;
    if (store_c && !ring_full_c) fill_nxt_c = fill_cnt + FW'(1);
    unique case (state)
      FILL: begin
        if (bus.freeze)                      state_nxt = HOLD;
        else if (fill_nxt_c == FW'(DEPTH))   state_nxt = RUN;
      end
      RUN: begin
        if (bus.freeze) state_nxt = HOLD;
      end
      HOLD: begin
        if (!bus.freeze) state_nxt = ring_full_c ? RUN : FILL;
      end
      default: state_nxt = FILL;
    endcase
  end

  // Write-side counters; decimation progress is frozen with the state machine
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      decim_cnt   <= '0;
      wr_ptr      <= '0;
      fill_cnt    <= '0;
      buffer_full <= 1'b0;
    end else begin
      if (accept_c) begin
        if (decim_cnt == DCW'(DECIMATE - 1)) decim_cnt <= '0;
        else                                 decim_cnt <= decim_cnt + DCW'(1);
      end
      if (store_c) wr_ptr <= wr_ptr + AW'(1);
      fill_cnt    <= fill_nxt_c;
      buffer_full <= (fill_nxt_c == FW'(DEPTH));
    end
  end

  // Ring storage: no reset, stale contents are masked by frame_fill
  always_ff @(posedge clock) begin
    if (store_c) ram[wr_ptr] <= bus.sample_in;
  end

  // Frame latch sees pre-store pointer/fill when a store coincides
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      frame_base <= '0;
      frame_fill <= '0;
    end else if (frame_start_c) begin
      frame_base <= ring_full_c ? wr_ptr : '0;
      frame_fill <= fill_cnt;
    end
  end

  // Look one column ahead so the registered read lands on the current hcount
  always_comb begin
    col_c     = CW'(bus.hcount) + CW'(1) - CW'(X_BEGIN);
    rd_addr_c = frame_base + col_c[AW-1:0];
    col_ok_c  = !col_c[CW-1] && (col_c < CW'(DEPTH)) && (col_c < CW'(frame_fill));
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) signal_out <= '0;
    else          signal_out <= col_ok_c ? ram[rd_addr_c] : '0;
  end

  assign bus.signal_out  = signal_out;
  assign bus.wr_ptr      = wr_ptr;
  assign bus.buffer_full = buffer_full;
endmodule

// File: tb/tb_waveform_buffer.sv
// Scoreboard bench for waveform_buffer: stimulus queues expectations, a negedge
// monitor compares them against the selected DUT output.
module tb_waveform_buffer;
  localparam int unsigned AW = 10;

  logic clock = 1'b0;
  logic reset_n;
  logic probe;

  always #5 clock = ~clock;

  waveform_buffer_if #(.AW(AW)) bus ();
  waveform_buffer_if #(.AW(AW)) bus4 ();

  assign bus4.hcount = bus.hcount;
  assign bus4.vcount = bus.vcount;
  assign bus4.freeze = 1'b0;

  waveform_buffer #(.DEPTH(1024), .AW(AW), .X_BEGIN(296), .DECIMATE(1)) dut (
    .clock(clock), .reset_n(reset_n), .bus(bus)
  );

  waveform_buffer #(.DEPTH(1024), .AW(AW), .X_BEGIN(296), .DECIMATE(4)) dut_d4 (
    .clock(clock), .reset_n(reset_n), .bus(bus4)
  );

  typedef struct {
    int sel;
    int val;
  } exp_t;

  exp_t  sb[$];
  exp_t  mon_e;
  int    mon_act;
  int    vectors = 0;
  int    miscompares = 0;
  string names [5] = '{"signal_out", "wr_ptr", "buffer_full", "d4_signal_out", "d4_wr_ptr"};

  function automatic int observe(input int sel);
    case (sel)
      0:       return int'(bus.signal_out);
      1:       return int'(bus.wr_ptr);
      2:       return int'(bus.buffer_full);
      3:       return int'(bus4.signal_out);
      default: return int'(bus4.wr_ptr);
    endcase
  endfunction

  // Monitor: compare whenever the stimulus side presents a probed cycle
  always @(negedge clock) begin
    if (probe) begin
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL scoreboard_underflow: probe with no expectation queued");
      end else begin
        mon_e   = sb.pop_front();
        mon_act = observe(mon_e.sel);
        vectors++;
        if (mon_act != mon_e.val) begin
          miscompares++;
          $display("FAIL %s (vector %0d): got %0d, expected %0d",
                   names[mon_e.sel], vectors, mon_act, mon_e.val);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_val(input int sel, input int val);
    sb.push_back('{sel, val});
    probe = 1'b1;
    tick();
    probe = 1'b0;
  endtask

  task automatic check_col(input int sel, input int h, input int val);
    bus.hcount = 11'(h - 1);
    tick();
    bus.hcount = 11'(h);
    expect_val(sel, val);
    bus.hcount = 11'd100;
  endtask

  task automatic push(input int v);
    bus.sample_valid = 1'b1;
    bus.sample_in    = 8'(v);
    tick();
    bus.sample_valid = 1'b0;
  endtask

  task automatic frame_start();
    bus.hcount = '0;
    bus.vcount = '0;
    tick();
    bus.hcount = 11'd100;
    bus.vcount = 10'd5;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    int guard;
    probe             = 1'b0;
    reset_n           = 1'b0;
    bus.sample_valid  = 1'b0;
    bus.sample_in     = '0;
    bus.freeze        = 1'b0;
    bus.hcount        = 11'd100;
    bus.vcount        = 10'd5;
    bus4.sample_valid = 1'b0;
    bus4.sample_in    = '0;
    tick();
    tick();

    // Reset state
    expect_val(0, 0);
    expect_val(1, 0);
    expect_val(2, 0);
    reset_n = 1'b1;
    tick();

    // Decimate-by-4 instance: only the 4th and 8th strobes are stored
    for (int k = 1; k <= 8; k++) begin
      bus4.sample_valid = 1'b1;
      bus4.sample_in    = 8'(k);
      tick();
    end
    bus4.sample_valid = 1'b0;

    // Five stores, partial fill
    for (int i = 1; i <= 5; i++) push(10 * i);
    expect_val(1, 5);
    expect_val(2, 0);
    frame_start();
    check_col(0, 295, 0);
    for (int i = 0; i < 5; i++) check_col(0, 296 + i, 10 * (i + 1));
    check_col(0, 301, 0);
    expect_val(2, 0);
    expect_val(4, 2);
    check_col(3, 296, 4);
    check_col(3, 297, 8);
    check_col(3, 298, 0);

    // Wrap past a full ring
    apply_reset();
    for (int i = 0; i < 1030; i++) push(i % 256);
    expect_val(1, 6);
    expect_val(2, 1);
    frame_start();
    check_col(0, 296, 6);
    check_col(0, 297, 7);
    check_col(0, 1318, 4);
    check_col(0, 1319, 5);
    check_col(0, 1320, 0);

    // Freeze for three frames while strobes keep arriving
    bus.freeze = 1'b1;
    tick();
    for (int f = 0; f < 3; f++) begin
      for (int j = 0; j < 10; j++) begin
        bus.sample_valid = 1'(j % 2);
        bus.sample_in    = 8'hAA;
        tick();
      end
      bus.sample_valid = 1'b0;
      frame_start();
      expect_val(1, 6);
      check_col(0, 296, 6);
      check_col(0, 800, 254);
      check_col(0, 1319, 5);
    end
    bus.freeze = 1'b0;
    tick();
    push(8'h77);
    expect_val(1, 7);
    expect_val(2, 1);
    frame_start();
    check_col(0, 1319, 8'h77);

    // Store coincident with the frame latch shows up one frame later
    bus.sample_valid = 1'b1;
    bus.sample_in    = 8'h55;
    bus.hcount       = '0;
    bus.vcount       = '0;
    tick();
    bus.sample_valid = 1'b0;
    bus.hcount       = 11'd100;
    bus.vcount       = 10'd5;
    check_col(0, 1319, 8'h77);
    expect_val(1, 8);
    frame_start();
    check_col(0, 1319, 8'h55);
    check_col(0, 296, 8);

    // Asynchronous reset mid-line
    check_col(0, 499, 211);
    bus.hcount = 11'd499;
    tick();
    bus.hcount = 11'd500;
    #1;
    reset_n = 1'b0;
    expect_val(0, 0);
    expect_val(1, 0);
    expect_val(2, 0);
    reset_n    = 1'b1;
    bus.hcount = 11'd100;
    tick();
    frame_start();
    check_col(0, 296, 0);

    guard = 0;
    while (sb.size() != 0 && guard < 20) begin
      tick();
      guard++;
    end
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
